uart_rx_axis: RTL and testbench
===============================

// Module: uart_rx_axis
// PURPOSE
//   UART receiver paired with the AXI-stream UART transmitter; it recovers frames from the serial line
//   and presents each word on an AXI-stream master.
//   Frame format: 1 start bit (0), DATA_WIDTH data bits LSB first, 1 stop bit (1), no parity.
//   Bit period = prescale*8 clk cycles, the same timing as the transmitter, so the two loop back directly.
//   The frame bit counter covers all DATA_WIDTH+2 bit slots, so no frame is truncated at DATA_WIDTH=16.
// PARAMETERS
//   DATA_WIDTH  8  data bits per frame and width of m_axis_tdata; legal 5..16
// PORTS
//   clk             in   1           single clock; all logic on rising edge
//   rst             in   1           synchronous, active-high reset
//   rxd             in   1           serial input, idle high, asynchronous to clk
//   prescale        in   16          bit period = prescale*8 clk; 0 is treated as 1
//   m_axis_tdata    out  DATA_WIDTH  received word
//   m_axis_tvalid   out  1           word available
//   m_axis_tready   in   1           consumer accepts word
//   busy            out  1           frame reception in progress
//   overrun_error   out  1           1-cycle pulse: new word completed while m_axis_tvalid still high
//   frame_error     out  1           1-cycle pulse: stop bit sampled as 0
// BEHAVIOUR
//   Reset values: m_axis_tdata=0, m_axis_tvalid=0, busy=0, overrun_error=0, frame_error=0.
//   Reset state: FSM=IDLE, synchroniser flops=1.
//   Input: rxd passes through a 2-flop synchroniser (rxd_s); all decisions use rxd_s (2-cycle delay).
//   prescale is latched at start detection and held for the whole frame.
//   Widths:
//     - cycle counter is 19 bits, holding prescale*8-1 with no overflow
//     - bit counter is $clog2(DATA_WIDTH+2) bits
//   FSM states: IDLE, START, DATA, STOP.
//   IDLE -> START when rxd_s==0.
//     - load cycle counter with prescale*4-1 (half bit); busy=1 from the next cycle
//   START: at counter==0, sample rxd_s.
//     - 1 -> false start: IDLE, busy=0
//     - 0 -> DATA: load prescale*8-1, bit_cnt=0
//   DATA: at each counter==0, shift in rxd_s at bit position bit_cnt (LSB first) and reload prescale*8-1.
//     - after bit DATA_WIDTH-1 -> STOP
//   STOP: at counter==0, sample the stop bit.
//     - 1 -> write word to m_axis_tdata and set m_axis_tvalid the next cycle
//     - 0 -> word discarded, frame_error pulses 1 cycle, m_axis_tvalid unchanged
//     - either case: IDLE, busy=0
//     - FSM waits in IDLE for rxd_s==1 before arming a new start
//       (held-low break is one frame_error only)
//   Sample point: the middle of each bit (prescale*4 clk after the start edge, then every prescale*8).
//   Latency: m_axis_tvalid rises (DATA_WIDTH+1.5)*prescale*8 + 3 clk after the rxd falling edge, +/-1 clk.
//   Handshake:
//     - word is transferred on a cycle with tvalid&&tready
//     - tvalid clears the next cycle unless a new word completes on that same cycle (then it stays 1)
//     - tdata stable while tvalid && !tready
//   Overrun: a new good word completing while tvalid==1 && !tready pulses overrun_error 1 cycle.
//     - the new word overwrites tdata; tvalid stays 1
//   Simultaneous completion and accept (tvalid&&tready on the completion cycle): no overrun; the new word loads.
//   Reset mid-frame: all state returns to reset values the next cycle; the partial word is lost.
//     - reception re-arms only after rxd_s is seen high
// TESTING
//   1 DATA_WIDTH=16, prescale=6: TX-format frame 16'hBEEF, tready=1 ->
//     tdata=16'hBEEF, tvalid 1 cycle, within 18*48+4 clk, no error pulses.
//   2 DATA_WIDTH=8, prescale=6: back-to-back frames 8'h55 then 8'hA3 ->
//     two words in order, busy low between frames for at most 1 bit time.
//   3 prescale=6: 20-cycle low glitch on rxd (less than the 24-cycle half bit) ->
//     no tvalid, busy returns to 0, next real frame 8'h3C received correctly.
//   4 prescale=6: frame 8'h81 with stop bit forced 0 ->
//     frame_error pulses exactly 1 cycle, tvalid stays 0.
//   5 tready=0: frames 8'h11 then 8'h22 ->
//     overrun_error 1 pulse, tdata=8'h22, tvalid=1 until tready asserted.
//   6 rst asserted for 1 cycle mid-data-bit 3 of a frame ->
//     all outputs at reset values, no word output; next frame 8'hC5 received correctly.

Source files
------------

// File: rtl/uart_rx_axis.sv
// UART receiver (start, DATA_WIDTH data bits LSB first, stop, no parity) feeding an AXI-stream master.
// Latency: tvalid rises about (DATA_WIDTH+1.5)*prescale*8 + 3 clk after the rxd falling edge.
// Backpressure: a single output register; a word completing while the last one is unaccepted overwrites it
// and pulses overrun_error.
// Ports: clk/rst (sync, active high), rxd serial in, prescale (bit period = prescale*8 clk),
//        m_axis_tdata/tvalid/tready output stream, busy, overrun_error and frame_error status pulses.
module uart_rx_axis #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  input  logic [15:0]           prescale,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  overrun_error,
  output logic                  frame_error
);

  localparam int BCW = $clog2(DATA_WIDTH + 2);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state_q;
  logic                  rxd_meta_q;
  logic                  rxd_s_q;
  logic                  armed_q;
  logic [15:0]           pre_q;
  logic [18:0]           cnt_q;
  logic [BCW-1:0]        bit_cnt_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic                  busy_q;
  logic                  ovr_q;
  logic                  ferr_q;

  // A prescale of 0 would give a zero-length bit; it is treated as 1.
  logic [15:0] pre_d;
  logic [18:0] half_bit_d;
  logic [18:0] full_bit_d;
  logic        cnt_zero;

  assign pre_d      = (prescale == 16'd0) ? 16'd1 : prescale;
  assign half_bit_d = {1'b0, pre_d, 2'b00} - 19'd1;
  assign full_bit_d = {pre_q, 3'b000} - 19'd1;
  assign cnt_zero   = (cnt_q == 19'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      armed_q    <= 1'b0;
      pre_q      <= 16'd1;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
      if (tvalid_q && m_axis_tready) tvalid_q <= 1'b0;
      if (!cnt_zero) cnt_q <= cnt_q - 19'd1;

      case (state_q)
        IDLE: begin
          // A new start is only accepted after the line has been seen high,
          // so a held-low break produces a single frame error.
          if (!armed_q) begin
            armed_q <= rxd_s_q;
          end else if (!rxd_s_q) begin
            state_q <= START;
            cnt_q   <= half_bit_d;
            pre_q   <= pre_d;
            busy_q  <= 1'b1;
            armed_q <= 1'b0;
          end
        end
        START: begin
          if (cnt_zero) begin
            if (rxd_s_q) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= DATA;
              cnt_q     <= full_bit_d;
              bit_cnt_q <= '0;
            end
          end
        end
        DATA: begin
          if (cnt_zero) begin
            // Right shift: after DATA_WIDTH samples the first bit sits at the LSB.
            shift_q <= {rxd_s_q, shift_q[DATA_WIDTH-1:1]};
            cnt_q   <= full_bit_d;
            if (bit_cnt_q == LAST_BIT) state_q <= STOP;
            else bit_cnt_q <= bit_cnt_q + BCW'(1);
          end
        end
        STOP: begin
          if (cnt_zero) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (rxd_s_q) begin
              tdata_q  <= shift_q;
              tvalid_q <= 1'b1;
              ovr_q    <= tvalid_q && !m_axis_tready;
            end else begin
              ferr_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign overrun_error = ovr_q;
  assign frame_error   = ferr_q;

endmodule

// File: tb/tb_uart_rx_axis.sv
module tb_uart_rx_axis;
  localparam int P   = 6;
  localparam int BIT = P * 8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rxd8, rxd16;
  logic [15:0] prescale;
  logic        tready8, tready16;
  logic [7:0]  tdata8;
  logic [15:0] tdata16;
  logic        tvalid8, tvalid16, busy8, busy16;
  logic        ov8_o, ov16_o, fe8_o, fe16_o;

  uart_rx_axis #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .rxd(rxd8), .prescale(prescale),
    .m_axis_tdata(tdata8), .m_axis_tvalid(tvalid8), .m_axis_tready(tready8),
    .busy(busy8), .overrun_error(ov8_o), .frame_error(fe8_o)
  );

  uart_rx_axis #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .rxd(rxd16), .prescale(prescale),
    .m_axis_tdata(tdata16), .m_axis_tvalid(tvalid16), .m_axis_tready(tready16),
    .busy(busy16), .overrun_error(ov16_o), .frame_error(fe16_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0]  exp8_q[$];
  logic [15:0] exp16_q[$];
  logic [7:0]  exp8_w;
  logic [15:0] exp16_w;
  int fe8 = 0, ov8 = 0, fe16 = 0, ov16 = 0, tv16_cyc = 0;
  int t_edge16 = 0, t_rise16 = 0;
  logic tv16_prev = 1'b0;
  logic gap_en = 1'b0;
  int gap_cur = 0, gap_max = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted word and counts status pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (fe8_o) fe8++;
      if (ov8_o) ov8++;
      if (fe16_o) fe16++;
      if (ov16_o) ov16++;
      if (tvalid8 && tready8) begin
        if (exp8_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word8 actual=%0h required=none", tdata8);
        end else begin
          exp8_w = exp8_q.pop_front();
          chk("word8", {24'd0, tdata8}, {24'd0, exp8_w});
        end
      end
      if (tvalid16 && tready16) begin
        if (exp16_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word16 actual=%0h required=none", tdata16);
        end else begin
          exp16_w = exp16_q.pop_front();
          chk("word16", {16'd0, tdata16}, {16'd0, exp16_w});
        end
      end
      if (tvalid16) tv16_cyc++;
      if (tvalid16 && !tv16_prev) t_rise16 = cyc;
      tv16_prev = tvalid16;
      if (gap_en) begin
        if (!busy8) gap_cur++;
        else begin
          if (gap_cur > gap_max) gap_max = gap_cur;
          gap_cur = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d, input int w, input logic stop, input bit wide);
    for (int i = 0; i < w + 2; i++) begin
      logic b;
      if (i == 0) b = 1'b0;
      else if (i == w + 1) b = stop;
      else b = d[i-1];
      if (wide) begin
        rxd16 = b;
        if (i == 0) t_edge16 = cyc;
      end else begin
        rxd8 = b;
      end
      tick(BIT);
    end
    if (wide) rxd16 = 1'b1; else rxd8 = 1'b1;
  endtask

  int lat, fe0, ov0;
  logic [7:0] part;

  initial begin
    rst = 1'b1; rxd8 = 1'b1; rxd16 = 1'b1; prescale = 16'(P);
    tready8 = 1'b1; tready16 = 1'b1;
    tick(5);
    chk("rst_tvalid8", {31'd0, tvalid8}, 32'd0);
    chk("rst_tdata8", {24'd0, tdata8}, 32'd0);
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_errs8", {30'd0, ov8_o, fe8_o}, 32'd0);
    chk("rst_tvalid16", {31'd0, tvalid16}, 32'd0);
    chk("rst_busy16", {31'd0, busy16}, 32'd0);
    rst = 1'b0;
    tick(5);

    // 1: 16-bit frame, latency window and single-cycle tvalid
    exp16_q.push_back(16'hBEEF);
    send(16'hBEEF, 16, 1'b1, 1'b1);
    tick(BIT);
    lat = t_rise16 - t_edge16;
    chk("t1_latency_ok", {31'd0, (lat >= 842 && lat <= 18 * 48 + 4)}, 32'd1);
    chk("t1_tvalid_cycles", tv16_cyc, 32'd1);
    chk("t1_errors16", fe16 + ov16, 32'd0);
    chk("t1_queue_empty", exp16_q.size(), 32'd0);

    // 2: back-to-back frames, short busy gap
    gap_cur = 0; gap_max = 0; gap_en = 1'b1;
    exp8_q.push_back(8'h55);
    exp8_q.push_back(8'hA3);
    send(16'h0055, 8, 1'b1, 1'b0);
    send(16'h00A3, 8, 1'b1, 1'b0);
    gap_en = 1'b0;
    tick(BIT);
    chk("t2_gap_ok", {31'd0, (gap_max >= 1 && gap_max <= BIT)}, 32'd1);
    chk("t2_queue_empty", exp8_q.size(), 32'd0);

    // 3: glitch shorter than a half bit is rejected
    rxd8 = 1'b0;
    tick(20);
    rxd8 = 1'b1;
    tick(BIT);
    chk("t3_busy_after_glitch", {31'd0, busy8}, 32'd0);
    chk("t3_tvalid_after_glitch", {31'd0, tvalid8}, 32'd0);
    exp8_q.push_back(8'h3C);
    send(16'h003C, 8, 1'b1, 1'b0);
    tick(BIT);
    chk("t3_queue_empty", exp8_q.size(), 32'd0);

    // 4: stop bit low -> single frame_error, no word
    fe0 = fe8;
    send(16'h0081, 8, 1'b0, 1'b0);
    tick(BIT);
    chk("t4_frame_error_cycles", fe8 - fe0, 32'd1);
    chk("t4_tvalid", {31'd0, tvalid8}, 32'd0);

    // 5: overrun with consumer stalled
    tready8 = 1'b0;
    ov0 = ov8;
    exp8_q.push_back(8'h22);
    send(16'h0011, 8, 1'b1, 1'b0);
    tick(10);
    send(16'h0022, 8, 1'b1, 1'b0);
    tick(BIT);
    chk("t5_overrun_cycles", ov8 - ov0, 32'd1);
    chk("t5_tdata", {24'd0, tdata8}, 32'h22);
    chk("t5_tvalid_held", {31'd0, tvalid8}, 32'd1);
    tick(BIT);
    chk("t5_tvalid_still_held", {31'd0, tvalid8}, 32'd1);
    tready8 = 1'b1;
    tick(3);
    chk("t5_tvalid_cleared", {31'd0, tvalid8}, 32'd0);
    chk("t5_queue_empty", exp8_q.size(), 32'd0);

    // 6: reset in the middle of data bit 3
    part = 8'h96;
    rxd8 = 1'b0;
    tick(BIT);
    for (int i = 0; i < 3; i++) begin
      rxd8 = part[i];
      tick(BIT);
    end
    rxd8 = part[3];
    tick(BIT / 2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    rxd8 = 1'b1;
    chk("t6_tdata_reset", {24'd0, tdata8}, 32'd0);
    chk("t6_tvalid_reset", {31'd0, tvalid8}, 32'd0);
    chk("t6_busy_reset", {31'd0, busy8}, 32'd0);
    chk("t6_errs_reset", {30'd0, ov8_o, fe8_o}, 32'd0);
    tick(2 * BIT);
    chk("t6_busy_idle", {31'd0, busy8}, 32'd0);
    exp8_q.push_back(8'hC5);
    send(16'h00C5, 8, 1'b1, 1'b0);
    tick(BIT);
    chk("t6_queue_empty", exp8_q.size(), 32'd0);

    chk("total_frame_errors8", fe8, 32'd1);
    chk("total_overruns8", ov8, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
